audio_out_stage: RTL and testbench
==================================

Name: audio_out_stage

Overview:
Downstream stage between the sound-toy core's continuous 16-bit PCM output and the framework audio outputs (left/right). Decimates the free-running PCM to a fixed sample rate using a fractional clock-enable. Applies click-free ramped volume and mute, plus a low-battery attenuation, and saturates the result. Drives both channels identically and flags clipping.

Parameters:
CLK_HZ, 50000000, input clock frequency in Hz
SAMPLE_HZ, 48000, output sample rate in Hz; must be less than CLK_HZ
ACC_W, 32, width of the fractional phase accumulator

Ports:
clk  in  1  system clock (50 MHz domain)
reset_n  in  1  synchronous reset, active-low
pcm_in  in  16  signed PCM from the sound core, sampled only on strobe
volume  in  4  volume setting; target gain = {volume,1'b0} in Q4 (volume 8 = unity)
mute  in  1  when 1, target gain = 0
low_batt  in  1  when 1, output is additionally attenuated by 6 dB (arithmetic shift right by 1)
sample_stb  out  1  one-cycle pulse at SAMPLE_HZ average rate
audio_l  out  16  signed output sample, left
audio_r  out  16  signed output sample, right (always equal to audio_l)
out_valid  out  1  one-cycle pulse when audio_l/audio_r update
clip  out  1  one-cycle pulse, coincident with out_valid, when saturation occurred
ramping  out  1  high while the current gain differs from the target gain

Behaviour:
- Reset: on any clk edge with reset_n=0, all of the following clear on that edge, including mid-ramp and mid-pipeline: acc=0, cur_gain=0, pipeline registers=0, all outputs=0.
- Fractional divider: each cycle, if acc+SAMPLE_HZ >= CLK_HZ then acc <= acc+SAMPLE_HZ-CLK_HZ and sample_stb=1; otherwise acc <= acc+SAMPLE_HZ.
  - Exactly SAMPLE_HZ pulses per CLK_HZ cycles with no drift.
  - At the defaults, the first pulse occurs on the 1042nd edge after reset release; pulse spacing is 1041 or 1042 cycles.
- Strobe cycle T: pcm_in is captured into s0. cur_gain updates in the same cycle.
- Gain ramp FSM, stepped on strobe only:
  - IDLE: cur_gain == target.
  - UP: cur_gain < target; cur_gain += 1 per strobe.
  - DOWN: cur_gain > target; cur_gain -= 1 per strobe.
  - On each strobe, the state is re-evaluated against the current target. A target change mid-ramp reverses direction on the next strobe without overshoot.
  - ramping = (state != IDLE).
  - Gain range is 0..30. A full 0->30 ramp takes 30 strobes.
  - After reset, cur_gain=0, so output fades in.
- T+1: p = s0 * cur_gain (signed 16 x unsigned 5 -> 22-bit signed), registered. cur_gain is the value after the T update.
- T+2: q = p >>> 4, then >>> 1 more if low_batt (low_batt is sampled at T+2).
  - Saturate q to the range -32768..32767.
  - audio_l and audio_r are set to the saturated value.
  - out_valid=1.
  - clip=1 if saturation changed the value.
- Latency: out_valid occurs exactly 2 cycles after sample_stb.
- Outputs hold their values between out_valid pulses.
- Changes to volume, mute or pcm_in between strobes have no effect until the next strobe.

Optional Feature:
Macro AUDIO_DCBLOCK_EN.
- Defined: a DC blocker is inserted between s0 and the multiplier.
  - Recurrence: y = x - x1 + y1 - (y1 >>> 8), with 18-bit signed internal width. x1 and y1 update only on strobe and reset to 0.
  - The result is saturated to 16 bits before the multiply.
  - Adds one pipeline stage: out_valid occurs 3 cycles after sample_stb.
- Undefined: no filter; latency is 2 cycles; no filter registers exist.

Test Plan:
1. Reset release with volume=8, mute=0, pcm_in=1000 -> first sample_stb on edge 1042; out_valid 2 cycles later (3 with AUDIO_DCBLOCK_EN); first audio_l=62 (1000*1>>4); reaches 1000 after 16 strobes; ramping drops to 0 at that point.
2. Count strobes over 50,000,000 cycles -> exactly 48000; every spacing is 1041 or 1042.
3. Settled at unity with pcm_in=-20000: set volume=15 (gain 30) -> gain steps +1 per strobe; clip pulses once the product exceeds range; audio_l saturates at -32768, never wraps positive.
4. Settled at gain 16 with pcm_in=4096: assert low_batt -> the next out_valid gives 2048; assert mute -> output decreases 256 per strobe to 0 over 16 strobes; deassert mute mid-ramp -> direction reverses on the next strobe.
5. Drive reset_n=0 for one cycle mid-ramp and mid-pipeline -> the next edge has all outputs 0 and cur_gain 0, and no out_valid is emitted for the in-flight sample.
6. With AUDIO_DCBLOCK_EN, constant pcm_in=8000 at unity -> the first output is about 8000 and decays toward 0, below 100 within 1500 strobes.

Source files
------------

// File: rtl/audio_out_stage.sv
// Decimates free-running PCM to SAMPLE_HZ, applies ramped volume/mute, low-battery
// attenuation and saturation. Define AUDIO_DCBLOCK_EN to insert a DC blocker before the gain.
module audio_out_stage #(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned SAMPLE_HZ = 48000,
    parameter int unsigned ACC_W     = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic signed [15:0] pcm_in,
    input  logic        [3:0]  volume,
    input  logic               mute,
    input  logic               low_batt,
    output logic               sample_stb,
    output logic signed [15:0] audio_l,
    output logic signed [15:0] audio_r,
    output logic               out_valid,
    output logic               clip,
    output logic               ramping
);
    typedef enum logic [1:0] {IDLE, UP, DOWN} ramp_state_t;

    localparam logic [ACC_W:0] STEP  = (ACC_W+1)'(SAMPLE_HZ);
    localparam logic [ACC_W:0] LIMIT = (ACC_W+1)'(CLK_HZ);

    // Returns {saturated, value}.
    function automatic logic [16:0] sat16(input logic signed [21:0] v);
        if (v > 22'sd32767)
            return {1'b1, 16'h7FFF};
        else if (v < -22'sd32768)
            return {1'b1, 16'h8000};
        else
            return {1'b0, v[15:0]};
    endfunction

    logic [ACC_W-1:0]   acc, acc_next;
    logic [ACC_W:0]     acc_sum;
    logic               stb;
    ramp_state_t        state, state_next;
    logic [4:0]         cur_gain, gain_next, target;
    logic signed [15:0] s0, mul_in;
    logic               mul_stb, v2;
    logic signed [21:0] prod, p, q;
    logic [16:0]        sat;

    always_comb begin
        acc_sum  = {1'b0, acc} + STEP;
        stb      = (acc_sum >= LIMIT);
        acc_next = stb ? ACC_W'(acc_sum - LIMIT) : ACC_W'(acc_sum);
    end

    // Direction is re-derived from the live target on every strobe, so a
    // mid-ramp target change reverses without overshoot.
    always_comb begin
        target     = mute ? '0 : {volume, 1'b0};
        gain_next  = cur_gain;
        state_next = state;
        if (stb) begin
            if (cur_gain < target)
                gain_next = cur_gain + 5'd1;
            else if (cur_gain > target)
                gain_next = cur_gain - 5'd1;
            if (gain_next < target)
                state_next = UP;
            else if (gain_next > target)
                state_next = DOWN;
            else
                state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            cur_gain <= '0;
        end else begin
            state    <= state_next;
            cur_gain <= gain_next;
        end
    end

    assign ramping = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc        <= '0;
            sample_stb <= 1'b0;
            s0         <= '0;
        end else begin
            acc        <= acc_next;
            sample_stb <= stb;
            if (stb)
                s0 <= pcm_in;
        end
    end

`ifdef AUDIO_DCBLOCK_EN
    logic signed [17:0] dc_x, dc_y, x1, y1;
    logic signed [15:0] dc_out;
    logic               dc_vld;
    logic [16:0]        dc_sat;

    always_comb begin
        dc_x   = 18'(s0);
        dc_y   = dc_x - x1 + y1 - (y1 >>> 8);
        dc_sat = sat16(22'(dc_y));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            x1     <= '0;
            y1     <= '0;
            dc_out <= '0;
            dc_vld <= 1'b0;
        end else begin
            dc_vld <= sample_stb;
            if (sample_stb) begin
                x1     <= dc_x;
                y1     <= dc_y;
                dc_out <= dc_sat[15:0];
            end
        end
    end

    assign mul_in  = dc_out;
    assign mul_stb = dc_vld;
`else
    assign mul_in  = s0;
    assign mul_stb = sample_stb;
`endif

    always_comb begin
        prod = 22'(mul_in) * 22'($signed({1'b0, cur_gain}));
        q    = low_batt ? (p >>> 5) : (p >>> 4);
        sat  = sat16(q);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            p         <= '0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            clip      <= 1'b0;
            audio_l   <= '0;
            audio_r   <= '0;
        end else begin
            v2        <= mul_stb;
            out_valid <= v2;
            clip      <= v2 & sat[16];
            if (mul_stb)
                p <= prod;
            if (v2) begin
                audio_l <= sat[15:0];
                audio_r <= sat[15:0];
            end
        end
    end

endmodule

// File: tb/tb_audio_out_stage.sv
// Directed self-checking bench for audio_out_stage, run at a scaled clock/sample
// ratio (1000/96) so whole divider periods fit in a short simulation.
module tb_audio_out_stage;
    localparam int unsigned CLK_HZ    = 1000;
    localparam int unsigned SAMPLE_HZ = 96;
    localparam int FIRST_EDGE = 11;   // first k with k*96 >= 1000
`ifdef AUDIO_DCBLOCK_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic signed [15:0] pcm_in = '0;
    logic [3:0]         volume = '0;
    logic               mute = 1'b0;
    logic               low_batt = 1'b0;
    logic               sample_stb;
    logic signed [15:0] audio_l, audio_r;
    logic               out_valid, clip, ramping;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    audio_out_stage #(
        .CLK_HZ(CLK_HZ),
        .SAMPLE_HZ(SAMPLE_HZ)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .pcm_in(pcm_in),
        .volume(volume),
        .mute(mute),
        .low_batt(low_batt),
        .sample_stb(sample_stb),
        .audio_l(audio_l),
        .audio_r(audio_r),
        .out_valid(out_valid),
        .clip(clip),
        .ramping(ramping)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_stb(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sample_stb) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic next_sample(output bit ok);
        bit s;
        wait_stb(s);
        ok = 1'b0;
        if (s) begin
            for (int i = 0; i < 8; i++) begin
                tick();
                if (out_valid) begin
                    ok = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        int n;
        bit seen;
        reset_n = 1'b0; volume = 4'd8; mute = 1'b0; low_batt = 1'b0; pcm_in = 16'sd1000;
        repeat (3) tick();
        checks++;
        if ({sample_stb, out_valid, clip, ramping} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b exp 0000", {sample_stb, out_valid, clip, ramping});
        end
        checks++;
        if (audio_l !== 16'sd0 || audio_r !== 16'sd0) begin
            errors++;
            $display("FAIL reset_audio got %0d/%0d exp 0/0", audio_l, audio_r);
        end
        reset_n = 1'b1;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            n++;
            if (sample_stb) seen = 1'b1;
        end
        checks++;
        if (!seen || n != FIRST_EDGE) begin
            errors++;
            $display("FAIL first_stb_edge got %0d exp %0d", n, FIRST_EDGE);
        end
        repeat (LAT - 1) tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_valid got %b exp 0", out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || audio_l !== 16'sd62 || audio_r !== 16'sd62) begin
            errors++;
            $display("FAIL first_sample got v=%b %0d exp v=1 62", out_valid, audio_l);
        end
        checks++;
        if (ramping !== 1'b1) begin
            errors++;
            $display("FAIL first_ramping got %b exp 1", ramping);
        end
    endtask

    task automatic test_divider();
        int cnt, last;
        cnt = 0;
        last = -1;
        for (int c = 0; c < int'(CLK_HZ); c++) begin
            tick();
            if (sample_stb) begin
                cnt++;
                if (last >= 0) begin
                    checks++;
                    if (!(c - last == 10 || c - last == 11)) begin
                        errors++;
                        $display("FAIL stb_spacing got %0d exp 10 or 11", c - last);
                    end
                end
                last = c;
            end
        end
        checks++;
        if (cnt != int'(SAMPLE_HZ)) begin
            errors++;
            $display("FAIL stb_count got %0d exp %0d", cnt, SAMPLE_HZ);
        end
    endtask

`ifdef AUDIO_DCBLOCK_EN
    task automatic test_dcblock();
        bit ok;
        int x1, y1, g, y, e;
        x1 = 1000; y1 = 1000; g = 1;
        pcm_in = 16'sd8000;
        for (int k = 0; k < 40; k++) begin
            next_sample(ok);
            if (g < 16) g++;
            y  = 8000 - x1 + y1 - (y1 >>> 8);
            x1 = 8000;
            y1 = y;
            e  = (y * g) >>> 4;
            checks++;
            if (!ok || audio_l !== 16'(e) || audio_r !== 16'(e)) begin
                errors++;
                $display("FAIL dcblock[%0d] got %0d exp %0d", k, audio_l, e);
            end
        end
    endtask
`else
    task automatic test_fade_in();
        bit ok;
        int e;
        for (int g = 2; g <= 16; g++) begin
            next_sample(ok);
            e = (1000 * g) >>> 4;
            checks++;
            if (!ok || audio_l !== 16'(e) || audio_r !== 16'(e)) begin
                errors++;
                $display("FAIL fade_in g=%0d got %0d exp %0d", g, audio_l, e);
            end
            checks++;
            if (ramping !== 1'(g < 16)) begin
                errors++;
                $display("FAIL fade_ramping g=%0d got %b exp %b", g, ramping, g < 16);
            end
        end
    endtask

    task automatic test_saturation();
        bit ok;
        int e;
        bit cl;
        pcm_in = -16'sd20000;
        next_sample(ok);
        checks++;
        if (!ok || audio_l !== -16'sd20000 || clip !== 1'b0) begin
            errors++;
            $display("FAIL sat_base got %0d exp -20000", audio_l);
        end
        volume = 4'd15;
        for (int g = 17; g <= 30; g++) begin
            next_sample(ok);
            e  = -1250 * g;
            cl = (e < -32768);
            if (cl) e = -32768;
            checks++;
            if (!ok || audio_l !== 16'(e) || audio_r !== 16'(e) || clip !== cl) begin
                errors++;
                $display("FAIL sat g=%0d got %0d clip=%b exp %0d clip=%b", g, audio_l, clip, e, cl);
            end
        end
        checks++;
        if (ramping !== 1'b0) begin
            errors++;
            $display("FAIL sat_ramping got %b exp 0", ramping);
        end
    endtask

    task automatic test_low_batt_mute();
        bit ok;
        bit bad;
        pcm_in = 16'sd4096;
        volume = 4'd8;
        for (int g = 29; g >= 16; g--) begin
            next_sample(ok);
            checks++;
            if (!ok || audio_l !== 16'(256 * g) || ramping !== 1'(g > 16)) begin
                errors++;
                $display("FAIL ramp_down g=%0d got %0d exp %0d", g, audio_l, 256 * g);
            end
        end
        low_batt = 1'b1;
        next_sample(ok);
        checks++;
        if (!ok || audio_l !== 16'sd2048) begin
            errors++;
            $display("FAIL low_batt got %0d exp 2048", audio_l);
        end
        low_batt = 1'b0;
        next_sample(ok);
        checks++;
        if (!ok || audio_l !== 16'sd4096) begin
            errors++;
            $display("FAIL low_batt_off got %0d exp 4096", audio_l);
        end
        mute = 1'b1;
        for (int g = 15; g >= 8; g--) begin
            next_sample(ok);
            checks++;
            if (!ok || audio_l !== 16'(256 * g) || ramping !== 1'b1) begin
                errors++;
                $display("FAIL mute g=%0d got %0d exp %0d", g, audio_l, 256 * g);
            end
        end
        mute = 1'b0;
        for (int g = 9; g <= 10; g++) begin
            next_sample(ok);
            checks++;
            if (!ok || audio_l !== 16'(256 * g)) begin
                errors++;
                $display("FAIL unmute g=%0d got %0d exp %0d", g, audio_l, 256 * g);
            end
        end
        // Inputs wiggled between strobes must not disturb the held output.
        pcm_in = -16'sd1;
        volume = 4'd0;
        bad = 1'b0;
        repeat (5) begin
            tick();
            if (out_valid !== 1'b0 || audio_l !== 16'sd2560) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL hold got %0d exp 2560", audio_l);
        end
        pcm_in = 16'sd4096;
        volume = 4'd8;
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen, vseen;
        int n;
        wait_stb(ok);
        reset_n = 1'b0;
        tick();
        checks++;
        if (!ok || {sample_stb, out_valid, clip, ramping} !== 4'b0000 ||
            audio_l !== 16'sd0 || audio_r !== 16'sd0) begin
            errors++;
            $display("FAIL mid_reset got flags=%b audio=%0d exp 0000 0",
                     {sample_stb, out_valid, clip, ramping}, audio_l);
        end
        reset_n = 1'b1;
        n = 0;
        seen = 1'b0;
        vseen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            n++;
            if (out_valid) vseen = 1'b1;
            if (sample_stb) seen = 1'b1;
        end
        checks++;
        if (!seen || n != FIRST_EDGE || vseen) begin
            errors++;
            $display("FAIL mid_reset_restart got edge=%0d stray_valid=%b exp %0d 0", n, vseen, FIRST_EDGE);
        end
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            tick();
            if (out_valid) ok = 1'b1;
        end
        checks++;
        if (!ok || audio_l !== 16'sd256 || ramping !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_fade got %0d exp 256", audio_l);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef AUDIO_DCBLOCK_EN
        test_dcblock();
        test_divider();
`else
        test_fade_in();
        test_divider();
        test_saturation();
        test_low_batt_mute();
        test_reset_mid();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
